// File: rtl/tone_synth.sv
// tone_synth: square-wave tone generator with linear attack/release envelope.
//   clk          in   system clock
//   resetN       in   asynchronous active-low reset
//   enable_sound in   level, 1 = note requested
//   freq[3:0]    in   note index 0..15 (C4..D#5)
//   audio_sample out  signed 16-bit sample, updated on sample_valid
//   sample_valid out  one-cycle strobe every SAMPLE_DIV clocks
//   tone_active  out  high whenever the envelope is not idle
module tone_synth #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int SAMPLE_DIV = 1042,
    parameter int AMP_MAX    = 8192,
    parameter int ENV_STEP   = 256
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        enable_sound,
    input  logic [3:0]  freq,
    output logic [15:0] audio_sample,
    output logic        sample_valid,
    output logic        tone_active
);
    localparam int TW = $clog2(SAMPLE_DIV);

    // The half-period table is only valid for a 50 MHz clock.
    if (CLK_HZ != 50_000_000) begin : g_clk_check
        $error("tone_synth: half-period table assumes a 50 MHz clock");
    end

    typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} state_t;

    state_t        state_q, state_d;
    logic [16:0]   hp_cnt_q, hp_cnt_d;
    logic          sq_q, sq_d;
    logic [TW-1:0] div_q;
    logic          tick;
    logic [14:0]   amp_q, amp_d;
    logic [15:0]   amp_up;
    logic [15:0]   sample_d;

    function automatic logic [16:0] half_m1(input logic [3:0] f);
        case (f)
            4'd0:    half_m1 = 17'd95555;
            4'd1:    half_m1 = 17'd90192;
            4'd2:    half_m1 = 17'd85130;
            4'd3:    half_m1 = 17'd80352;
            4'd4:    half_m1 = 17'd75842;
            4'd5:    half_m1 = 17'd71585;
            4'd6:    half_m1 = 17'd67567;
            4'd7:    half_m1 = 17'd63775;
            4'd8:    half_m1 = 17'd60195;
            4'd9:    half_m1 = 17'd56817;
            4'd10:   half_m1 = 17'd53628;
            4'd11:   half_m1 = 17'd50618;
            4'd12:   half_m1 = 17'd47777;
            4'd13:   half_m1 = 17'd45096;
            4'd14:   half_m1 = 17'd42565;
            default: half_m1 = 17'd40176;
        endcase
    endfunction

    assign tick   = div_q == TW'(SAMPLE_DIV - 1);
    assign amp_up = {1'b0, amp_q} + 16'(ENV_STEP);

    // The new note index is only picked up at a reload, so a retune never
    // truncates the half-period in progress.
    always_comb begin
        hp_cnt_d = hp_cnt_q - 17'd1;
        sq_d     = sq_q;
        if (state_q == IDLE) begin
            hp_cnt_d = half_m1(freq);
            sq_d     = 1'b1;
        end else if (hp_cnt_q == '0) begin
            hp_cnt_d = half_m1(freq);
            sq_d     = ~sq_q;
        end
    end

    always_comb begin
        amp_d = amp_q;
        if (tick && state_q == ATTACK)
            amp_d = amp_up >= 16'(AMP_MAX) ? 15'(AMP_MAX) : amp_up[14:0];
        if (tick && state_q == RELEASE)
            amp_d = amp_q <= 15'(ENV_STEP) ? '0 : amp_q - 15'(ENV_STEP);
    end

    // Sample uses the post-update amplitude of this tick.
    assign sample_d = state_q == IDLE ? 16'd0 : sq_q ? {1'b0, amp_d} : 16'd0 - {1'b0, amp_d};

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = enable_sound ? ATTACK : IDLE;
            ATTACK:  state_d = !enable_sound ? RELEASE : (tick && amp_up >= 16'(AMP_MAX)) ? SUSTAIN : ATTACK;
            SUSTAIN: state_d = enable_sound ? SUSTAIN : RELEASE;
            RELEASE: state_d = enable_sound ? ATTACK : (tick && amp_q <= 15'(ENV_STEP)) ? IDLE : RELEASE;
            default: state_d = IDLE;
        endcase
    end

    always_comb tone_active = state_q != IDLE;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            hp_cnt_q     <= '0;
            sq_q         <= 1'b1;
            div_q        <= '0;
            amp_q        <= '0;
            audio_sample <= '0;
            sample_valid <= 1'b0;
        end else begin
            hp_cnt_q     <= hp_cnt_d;
            sq_q         <= sq_d;
            div_q        <= tick ? '0 : div_q + TW'(1);
            amp_q        <= amp_d;
            audio_sample <= tick ? sample_d : audio_sample;
            sample_valid <= tick;
        end
    end
endmodule

// File: tb/tb_tone_synth.sv
// tb_tone_synth: directed self-checking bench for tone_synth (short sample period).
module tb_tone_synth;
    localparam int DIV = 32;

    logic        clk = 1'b0;
    logic        resetN = 1'b1;
    logic        enable_sound = 1'b0;
    logic [3:0]  freq = 4'd9;
    logic [15:0] audio_sample;
    logic        sample_valid;
    logic        tone_active;

    int checks = 0;
    int errors = 0;

    tone_synth #(.SAMPLE_DIV(DIV)) dut (
        .clk(clk),
        .resetN(resetN),
        .enable_sound(enable_sound),
        .freq(freq),
        .audio_sample(audio_sample),
        .sample_valid(sample_valid),
        .tone_active(tone_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_sample(output int s, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!sample_valid && n < 2 * DIV);
        chk("sample_strobe", int'(sample_valid), 1);
        s = int'($signed(audio_sample));
    endtask

    initial begin
        int s, n, e;
        #2 resetN = 1'b0;
        step();
        step();
        chk("rst_sample", int'(audio_sample), 0);
        chk("rst_valid", int'(sample_valid), 0);
        chk("rst_active", int'(tone_active), 0);
        #3 resetN = 1'b1;
        wait_sample(s, n);
        chk("first_tick_gap", n, DIV);
        chk("idle_sample", s, 0);
        wait_sample(s, n);
        chk("idle_gap", n, DIV);

        // basic note, then retune mid half-period
        freq = 4'd15;
        enable_sound = 1'b1;
        step();
        chk("active_next_clk", int'(tone_active), 1);
        e = 0;
        for (int k = 1; k <= 34; k++) begin
            wait_sample(s, n);
            e += n;
            chk("attack_gap", n, k == 1 ? DIV - 1 : DIV);
            chk("attack_amp", s, 256 * (k > 32 ? 32 : k));
        end
        freq = 4'd0;
        for (int k = 0; k < 1300 && s > 0; k++) begin
            wait_sample(s, n);
            e += n;
        end
        chk("flip_edge", e, 40191);
        chk("flip_amp", s, -8192);

        // release from sustain
        enable_sound = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            wait_sample(s, n);
            chk("release_amp", s, -(8192 - 256 * k));
            chk("release_active", int'(tone_active), k < 32 ? 1 : 0);
        end
        for (int k = 0; k < 2; k++) begin
            wait_sample(s, n);
            chk("post_release", s, 0);
        end

        // retrigger from amp=4096 during release
        freq = 4'd9;
        enable_sound = 1'b1;
        for (int k = 1; k <= 32; k++) wait_sample(s, n);
        chk("sustain_amp", s, 8192);
        enable_sound = 1'b0;
        for (int k = 1; k <= 16; k++) wait_sample(s, n);
        chk("rel_mid_amp", s, 4096);
        enable_sound = 1'b1;
        wait_sample(s, n);
        chk("retrigger_amp", s, 4352);
        chk("retrigger_active", int'(tone_active), 1);
        enable_sound = 1'b0;
        for (int k = 0; k < 40 && tone_active; k++) wait_sample(s, n);
        chk("drain_idle", int'(tone_active), 0);

        // one-cycle enable pulse
        repeat (5) step();
        enable_sound = 1'b1;
        step();
        chk("pulse_active", int'(tone_active), 1);
        enable_sound = 1'b0;
        step();
        chk("pulse_release", int'(tone_active), 1);
        wait_sample(s, n);
        chk("pulse_sample", s, 0);
        chk("pulse_idle", int'(tone_active), 0);
        wait_sample(s, n);
        chk("pulse_after", s, 0);

        // asynchronous reset mid-sustain
        enable_sound = 1'b1;
        for (int k = 1; k <= 33; k++) wait_sample(s, n);
        chk("pre_reset_amp", s, 8192);
        @(posedge clk);
        #3 resetN = 1'b0;
        enable_sound = 1'b0;
        #1;
        chk("async_sample", int'(audio_sample), 0);
        chk("async_valid", int'(sample_valid), 0);
        chk("async_active", int'(tone_active), 0);
        repeat (3) @(posedge clk);
        #2 resetN = 1'b1;
        wait_sample(s, n);
        chk("post_reset_gap", n, DIV);
        chk("post_reset_sample", s, 0);
        chk("post_reset_active", int'(tone_active), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
